// File: rtl/game_sound_seq.sv
// Game music sequencer: plays the track selected by the game state, inserting silent
// beats on every state change, with per-track looping or one-shot playback.
// Ports:
//   clk, rst (async, active-high)
//   beat       one-cycle note-advance tick
//   mute       forces silent tone outputs; sequencing is unaffected
//   state      game state, which is also the index of the track to play
//   rom_l/r    tone ROM data for {track, note_addr}, combinational
//   track      registered active track index
//   note_addr  registered note index within the track
//   freqL/R    registered tone periods (SILENT when not sounding)
//   done       one-cycle pulse when a one-shot track finishes
module game_sound_seq #(
  parameter int unsigned NTRACK = 10,
  parameter int unsigned SW = 4,
  parameter int unsigned AW = 12,
  parameter int unsigned FW = 26,
  parameter int unsigned GAP = 4,
  parameter int unsigned SILENT = 50000000,
  parameter logic [NTRACK-1:0] LOOP = '1,
  parameter logic [NTRACK*AW-1:0] TRACK_LEN = {NTRACK{AW'(64)}}
) (
  input  logic clk,
  input  logic rst,
  input  logic beat,
  input  logic mute,
  input  logic [SW-1:0] state,
  input  logic [FW-1:0] rom_l,
  input  logic [FW-1:0] rom_r,
  output logic [SW-1:0] track,
  output logic [AW-1:0] note_addr,
  output logic [FW-1:0] freqL,
  output logic [FW-1:0] freqR,
  output logic done
);

  localparam int unsigned GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_GAP,
    S_PLAY,
    S_HOLD,
    S_OFF
  } fsm_t;

  fsm_t fsm_q, fsm_d;
  logic [SW-1:0] st_q, st_d;
  logic [SW-1:0] track_q, track_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic done_q, done_d;
  logic [FW-1:0] freql_q, freql_d;
  logic [FW-1:0] freqr_q, freqr_d;

  logic change;
  logic track_ok;
  logic [AW-1:0] cur_len;
  logic cur_loop;
  logic last_note;
  fsm_t gap_exit;

  assign change = (state != st_q);
  assign track_ok = (int'(track_q) < int'(NTRACK));
  assign gap_exit = track_ok ? S_PLAY : S_OFF;

  // Per-track length and loop flag for the active track.
  always_comb begin
    cur_len = AW'(1);
    cur_loop = 1'b0;
    for (int t = 0; t < int'(NTRACK); t++) begin
      if (track_q == SW'(t)) begin
        cur_len = TRACK_LEN[t*AW +: AW];
        cur_loop = LOOP[t];
      end
    end
  end

  assign last_note = (addr_q == cur_len - AW'(1));

  always_comb begin
    fsm_d = fsm_q;
    st_d = st_q;
    track_d = track_q;
    addr_d = addr_q;
    gap_d = gap_q;
    done_d = 1'b0;
    if (change) begin
      // A state change wins over any beat in the same cycle.
      st_d = state;
      track_d = state;
      addr_d = '0;
      gap_d = '0;
      fsm_d = S_GAP;
    end else begin
      unique case (fsm_q)
        S_GAP: begin
          if (GAP == 0) begin
            fsm_d = gap_exit;
          end else if (beat) begin
            if (gap_q == GCW'(GAP - 1)) begin
              gap_d = '0;
              fsm_d = gap_exit;
            end else begin
              gap_d = gap_q + GCW'(1);
            end
          end
        end
        S_PLAY: begin
          if (beat) begin
            if (!last_note) begin
              addr_d = addr_q + AW'(1);
            end else if (cur_loop) begin
              addr_d = '0;
            end else begin
              fsm_d = S_HOLD;
              done_d = 1'b1;
            end
          end
        end
        S_HOLD: fsm_d = S_HOLD;
        S_OFF: fsm_d = S_OFF;
        default: fsm_d = S_GAP;
      endcase
    end
  end

  // Tone outputs trail note_addr/FSM by one clock; ROM is addressed by the
  // registered track and note index.
  always_comb begin
    freql_d = FW'(SILENT);
    freqr_d = FW'(SILENT);
    if (!mute && fsm_q == S_PLAY) begin
      freql_d = rom_l;
      freqr_d = rom_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_GAP;
      st_q <= '0;
      track_q <= '0;
      addr_q <= '0;
      gap_q <= '0;
      done_q <= 1'b0;
      freql_q <= FW'(SILENT);
      freqr_q <= FW'(SILENT);
    end else begin
      fsm_q <= fsm_d;
      st_q <= st_d;
      track_q <= track_d;
      addr_q <= addr_d;
      gap_q <= gap_d;
      done_q <= done_d;
      freql_q <= freql_d;
      freqr_q <= freqr_d;
    end
  end

  assign track = track_q;
  assign note_addr = addr_q;
  assign freqL = freql_q;
  assign freqR = freqr_q;
  assign done = done_q;

endmodule

// File: tb/tb_game_sound_seq.sv
// Directed bench for game_sound_seq: gap, looping, one-shot, change priority,
// out-of-range track, mute and asynchronous reset.
module tb_game_sound_seq;

  localparam int unsigned NTRACK = 10;
  localparam int unsigned SW = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned FW = 26;
  localparam int unsigned GAP = 4;
  localparam int unsigned SILENT = 50000000;
  localparam logic [NTRACK-1:0] LOOP = 10'b11_1111_1101;
  localparam logic [NTRACK*AW-1:0] TLEN =
    {{7{12'd64}}, 12'd8, 12'd2, 12'd3};

  logic clk = 1'b0;
  logic rst;
  logic beat;
  logic mute;
  logic [SW-1:0] state;
  logic [FW-1:0] rom_l, rom_r;
  logic [SW-1:0] track;
  logic [AW-1:0] note_addr;
  logic [FW-1:0] freqL, freqR;
  logic done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_l = FW'({track, note_addr}) + FW'(1000);
  assign rom_r = FW'({track, note_addr}) + FW'(2000);

  game_sound_seq #(
    .NTRACK(NTRACK), .SW(SW), .AW(AW), .FW(FW), .GAP(GAP),
    .SILENT(SILENT), .LOOP(LOOP), .TRACK_LEN(TLEN)
  ) dut (
    .clk(clk), .rst(rst), .beat(beat), .mute(mute),
    .state(state), .rom_l(rom_l), .rom_r(rom_r),
    .track(track), .note_addr(note_addr),
    .freqL(freqL), .freqR(freqR), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  function automatic logic [31:0] tone(input int t, input int a, input int off);
    return 32'(t * 4096 + a + off);
  endfunction

  localparam int EXP36 [7] = '{1, 2, 0, 1, 2, 0, 1};

  initial begin
    rst = 1'b1;
    beat = 1'b0;
    mute = 1'b0;
    state = '0;
    #12;
    chk("rst_track", 32'(track), 0);
    chk("rst_addr", 32'(note_addr), 0);
    chk("rst_freqL", 32'(freqL), SILENT);
    chk("rst_freqR", 32'(freqR), SILENT);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    chk("gap_idle", 32'(freqL), SILENT);
    for (int i = 0; i < 4; i++) begin
      do_beat();
      chk("gap_beat", 32'(freqL), SILENT);
    end
    tick();
    chk("play_l00", 32'(freqL), tone(0, 0, 1000));
    chk("play_r00", 32'(freqR), tone(0, 0, 2000));

    for (int i = 0; i < 7; i++) begin
      do_beat();
      chk("loop_addr", 32'(note_addr), 32'(EXP36[i]));
      chk("loop_done", 32'(done), 0);
    end

    mute = 1'b1;
    tick();
    chk("mute_sil", 32'(freqL), SILENT);
    do_beat();
    chk("mute_adv", 32'(note_addr), 2);
    tick();
    chk("mute_silR", 32'(freqR), SILENT);
    mute = 1'b0;
    tick();
    chk("unmute", 32'(freqL), tone(0, 2, 1000));

    state = 4'd1;
    tick();
    chk("chg_track", 32'(track), 1);
    chk("chg_addr", 32'(note_addr), 0);
    for (int i = 0; i < 4; i++) do_beat();
    tick();
    chk("os_play", 32'(freqL), tone(1, 0, 1000));
    do_beat();
    chk("os_addr1", 32'(note_addr), 1);
    chk("os_nodone", 32'(done), 0);
    do_beat();
    chk("os_done", 32'(done), 1);
    chk("os_hold", 32'(note_addr), 1);
    tick();
    chk("os_pulse", 32'(done), 0);
    chk("os_sil", 32'(freqL), SILENT);
    do_beat();
    chk("hold_addr", 32'(note_addr), 1);
    chk("hold_done", 32'(done), 0);
    chk("hold_sil", 32'(freqR), SILENT);

    state = 4'd2;
    tick();
    for (int i = 0; i < 4; i++) do_beat();
    for (int i = 0; i < 5; i++) do_beat();
    chk("pre_addr5", 32'(note_addr), 5);
    state = 4'd3;
    do_beat();
    chk("prio_addr", 32'(note_addr), 0);
    chk("prio_track", 32'(track), 3);
    tick();
    chk("prio_sil", 32'(freqL), SILENT);
    for (int i = 0; i < 3; i++) do_beat();
    tick();
    chk("prio_gap3", 32'(freqL), SILENT);
    do_beat();
    tick();
    chk("prio_play", 32'(freqL), tone(3, 0, 1000));

    state = 4'd12;
    tick();
    for (int i = 0; i < 4; i++) do_beat();
    for (int i = 0; i < 3; i++) do_beat();
    tick();
    chk("off_sil", 32'(freqL), SILENT);
    chk("off_track", 32'(track), 12);
    chk("off_addr", 32'(note_addr), 0);

    state = 4'd2;
    tick();
    for (int i = 0; i < 4; i++) do_beat();
    do_beat();
    do_beat();
    chk("pre_rst", 32'(note_addr), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_track", 32'(track), 0);
    chk("arst_addr", 32'(note_addr), 0);
    chk("arst_freqL", 32'(freqL), SILENT);
    chk("arst_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    chk("post_chg", 32'(track), 2);
    chk("post_addr", 32'(note_addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
